demux_2_way_reg: RTL and testbench
==================================

# demux_2_way_reg

Registered, flow-controlled 1-to-2 demultiplexer for the FRiscV pipelined core. It takes one valid/ready input stream and steers each accepted word to output A or B, chosen by a per-transfer select. Each output has a single-entry holding register. The block sits wherever one producer feeds two consumers, for example a shared memory response returned to either the fetch stage or the memory stage, and it provides the split complementary to the datapath selection muxes.

## Interface
Parameters:
- DEMUX_WIDTH, 8, data width of input and both outputs

Ports:
- clk  in  1  core clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- flush_in  in  1  synchronous clear of both holding registers
- valid_in  in  1  input word present
- ready_out  out  1  block accepts input this cycle
- sel_in  in  1  destination for the input word: 0 routes to A, 1 routes to B
- data_in  in  DEMUX_WIDTH  input word
- a_valid_out  out  1  holding register A is full
- a_ready_in  in  1  consumer A accepts this cycle
- a_data_out  out  DEMUX_WIDTH  holding register A contents
- b_valid_out  out  1  holding register B is full
- b_ready_in  in  1  consumer B accepts this cycle
- b_data_out  out  DEMUX_WIDTH  holding register B contents

## Operation
- Each output slot has a two-state FSM with states EMPTY and FULL. The FSM is held in a one-bit flag.
- Transfer rules:
  - An input transfer occurs when valid_in and ready_out are both 1.
  - An output transfer on X occurs when x_valid_out and x_ready_in are both 1.
- ready_out = !flush_in && (sel_in ? (!b_full || b_ready_in) : (!a_full || a_ready_in)).
- Slot X transitions:
  - EMPTY → FULL on an input transfer with sel_in selecting X. The slot captures data_in.
  - FULL → FULL on a simultaneous output transfer on X and input transfer into X. The slot captures the new data_in.
  - FULL → EMPTY on an output transfer on X with no input transfer into X.
  - FULL holds its data unchanged while x_ready_in is 0.
- The slot that sel_in does not select is unaffected by the input. Both slots can drain in the same cycle.
- flush_in = 1 forces both slots to EMPTY at the next edge. It overrides any input or output transfer in that cycle, and the input word is not accepted because ready_out is 0.
- x_data_out always shows the slot register. Its value while EMPTY is don't-care but stable. The implementation keeps the last value and updates only on capture.
- Data passes through with no arithmetic or width change.

## Timing
- Reset values: a_valid_out = 0, b_valid_out = 0, a_data_out = 0, b_data_out = 0. ready_out follows its equation from reset values, so it is 1 when flush_in = 0.
- Reset asserted mid-operation empties both slots immediately, without waiting for a clock edge. Held data is lost.
- Latency: a word accepted at edge k appears on x_valid_out and x_data_out after edge k and stays there until its output transfer.
- Throughput is one word per cycle per output when the consumer holds x_ready_in = 1.
- Combinational paths:
  - ready_out depends combinationally on sel_in, flush_in, a_ready_in and b_ready_in.
  - x_valid_out and x_data_out are registered.
- Once asserted, x_valid_out and x_data_out stay stable until the output transfer or a flush.
- The block has no ordering guarantee between A and B. Words to the same output stay in order.

## Structure
- friscv_pkg holds typedef slot_state_e {SLOT_EMPTY, SLOT_FULL} for use by the bench and other stream blocks.
- Natural sub-module: stream_slot. It is a one-entry register with valid/ready, parameter WIDTH, and inputs wr_en, flush_in and rd_ready. It is instantiated twice.
- The top level contains only the steering logic and the ready_out equation.

## Test plan
- Reset check: hold rst = 1 mid-stream with A full (0x5A) → a_valid_out drops to 0 without a clock edge; after release, ready_out = 1.
- Basic routing:
  - Drive data_in = 0x11 with sel_in = 0 and 0x22 with sel_in = 1 on consecutive cycles, with both readies at 1.
  - Required: a_data_out = 0x11 one cycle after acceptance, then b_data_out = 0x22, each valid for exactly one cycle.
- Backpressure:
  - Hold a_ready_in = 0, fill A with 0xA1, then present 0xA2 with sel_in = 0 → ready_out = 0 and A holds 0xA1.
  - Raise a_ready_in → 0xA1 drains and 0xA2 is captured at the same edge.
- Independence: A full and stalled; stream 0x30, 0x31, 0x32 to B with b_ready_in = 1 → all three are accepted back to back and A is unchanged.
- Flush priority: assert flush_in with both slots full and valid_in = 1 → ready_out = 0, both valids are 0 next cycle, and the input word is not accepted.
- Randomized ordering: random valid, select and ready patterns over 1000 words → the scoreboard shows per-output order preserved with no loss or duplication.

Source files
------------

// File: rtl/friscv_pkg.sv
// Shared types and constants for FRiscV stream blocks.
package friscv_pkg;

  localparam int unsigned DEMUX_WIDTH_DEFAULT = 8;

  // Occupancy of a single-entry stream holding register.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage : friscv_pkg

// File: rtl/demux_2_way_reg_stream_slot.sv
// One-entry valid/ready holding register. Data is kept after drain and
// changes only on capture.
module stream_slot
  import friscv_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_in,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  slot_state_e      r_state;
  logic [WIDTH-1:0] r_data;

  // Slot FSM: flush wins, then capture (which also covers drain+refill), then drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else if (flush_in) begin
      r_state <= SLOT_EMPTY;
    end else if (wr_en) begin
      r_state <= SLOT_FULL;
      r_data  <= wr_data;
    end else if ((r_state == SLOT_FULL) && rd_ready) begin
      r_state <= SLOT_EMPTY;
    end
  end

  assign rd_valid = (r_state == SLOT_FULL);
  assign rd_data  = r_data;

endmodule : stream_slot

// File: rtl/demux_2_way_reg.sv
// Registered, flow-controlled 1-to-2 stream demultiplexer.
module demux_2_way_reg
  import friscv_pkg::*;
#(
  parameter int unsigned DEMUX_WIDTH = DEMUX_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic                   sel_in,
  input  logic [DEMUX_WIDTH-1:0] data_in,
  output logic                   a_valid_out,
  input  logic                   a_ready_in,
  output logic [DEMUX_WIDTH-1:0] a_data_out,
  output logic                   b_valid_out,
  input  logic                   b_ready_in,
  output logic [DEMUX_WIDTH-1:0] b_data_out
);

  logic w_a_full;
  logic w_b_full;
  logic w_accept;
  logic w_a_wr;
  logic w_b_wr;

  // Accept when the selected slot is empty or drains this cycle; flush blocks input.
  assign ready_out = !flush_in &&
                     (sel_in ? (!w_b_full || b_ready_in) : (!w_a_full || a_ready_in));
  assign w_accept  = valid_in && ready_out;
  assign w_a_wr    = w_accept && !sel_in;
  assign w_b_wr    = w_accept && sel_in;

  stream_slot #(.WIDTH(DEMUX_WIDTH)) u_slot_a (
    .clk      (clk),
    .rst      (rst),
    .flush_in (flush_in),
    .wr_en    (w_a_wr),
    .wr_data  (data_in),
    .rd_ready (a_ready_in),
    .rd_valid (w_a_full),
    .rd_data  (a_data_out)
  );

  stream_slot #(.WIDTH(DEMUX_WIDTH)) u_slot_b (
    .clk      (clk),
    .rst      (rst),
    .flush_in (flush_in),
    .wr_en    (w_b_wr),
    .wr_data  (data_in),
    .rd_ready (b_ready_in),
    .rd_valid (w_b_full),
    .rd_data  (b_data_out)
  );

  assign a_valid_out = w_a_full;
  assign b_valid_out = w_b_full;

endmodule : demux_2_way_reg

// File: tb/tb_demux_2_way_reg.sv
// Directed and randomized bench for demux_2_way_reg with a queue-based model.
module tb_demux_2_way_reg;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         flush_in;
  logic         valid_in;
  logic         ready_out;
  logic         sel_in;
  logic [W-1:0] data_in;
  logic         a_valid_out;
  logic         a_ready_in;
  logic [W-1:0] a_data_out;
  logic         b_valid_out;
  logic         b_ready_in;
  logic [W-1:0] b_data_out;

  int total = 0;
  int bad   = 0;

  // Reference model: one FIFO of outstanding words per output.
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  int accepted = 0;
  int popped   = 0;
  int dropped  = 0;

  demux_2_way_reg #(.DEMUX_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_in    (flush_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .sel_in      (sel_in),
    .data_in     (data_in),
    .a_valid_out (a_valid_out),
    .a_ready_in  (a_ready_in),
    .a_data_out  (a_data_out),
    .b_valid_out (b_valid_out),
    .b_ready_in  (b_ready_in),
    .b_data_out  (b_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One randomized cycle: drive, check against model, advance clock, update model.
  task automatic model_cycle(input logic v, input logic s, input logic [W-1:0] d,
                             input logic ar, input logic br, input logic fl);
    bit exp_rdy;
    bit acc;
    valid_in = v; sel_in = s; data_in = d;
    a_ready_in = ar; b_ready_in = br; flush_in = fl;
    #1;
    exp_rdy = !fl && (s ? (qb.size() == 0 || br) : (qa.size() == 0 || ar));
    chk("rand_ready", 32'(ready_out), 32'(exp_rdy));
    chk("rand_a_valid", 32'(a_valid_out), 32'(qa.size()));
    chk("rand_b_valid", 32'(b_valid_out), 32'(qb.size()));
    if (qa.size() > 0) chk("rand_a_data", 32'(a_data_out), 32'(qa[0]));
    if (qb.size() > 0) chk("rand_b_data", 32'(b_data_out), 32'(qb[0]));
    acc = v && exp_rdy;
    tick();
    if (fl) begin
      dropped += qa.size() + qb.size();
      qa.delete();
      qb.delete();
    end else begin
      if (qa.size() > 0 && ar) begin void'(qa.pop_front()); popped++; end
      if (qb.size() > 0 && br) begin void'(qb.pop_front()); popped++; end
      if (acc) begin
        accepted++;
        if (s) qb.push_back(d); else qa.push_back(d);
      end
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1; flush_in = 1'b0; valid_in = 1'b0; sel_in = 1'b0;
    data_in = '0; a_ready_in = 1'b0; b_ready_in = 1'b0;
    tick(); tick();

    // Reset values
    chk("rst_a_valid", 32'(a_valid_out), 32'd0);
    chk("rst_b_valid", 32'(b_valid_out), 32'd0);
    chk("rst_a_data", 32'(a_data_out), 32'd0);
    chk("rst_b_data", 32'(b_data_out), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd1);
    rst = 1'b0;
    tick();

    // Basic routing
    a_ready_in = 1'b1; b_ready_in = 1'b1;
    valid_in = 1'b1; sel_in = 1'b0; data_in = 8'h11;
    #1 chk("route_ready0", 32'(ready_out), 32'd1);
    tick();
    sel_in = 1'b1; data_in = 8'h22;
    chk("route_a_valid", 32'(a_valid_out), 32'd1);
    chk("route_a_data", 32'(a_data_out), 32'h11);
    chk("route_b_empty", 32'(b_valid_out), 32'd0);
    tick();
    valid_in = 1'b0;
    chk("route_a_drained", 32'(a_valid_out), 32'd0);
    chk("route_b_valid", 32'(b_valid_out), 32'd1);
    chk("route_b_data", 32'(b_data_out), 32'h22);
    tick();
    chk("route_b_drained", 32'(b_valid_out), 32'd0);

    // Backpressure on A
    a_ready_in = 1'b0;
    valid_in = 1'b1; sel_in = 1'b0; data_in = 8'hA1;
    tick();
    data_in = 8'hA2;
    #1 chk("bp_ready_low", 32'(ready_out), 32'd0);
    tick();
    chk("bp_a_hold_valid", 32'(a_valid_out), 32'd1);
    chk("bp_a_hold_data", 32'(a_data_out), 32'hA1);
    a_ready_in = 1'b1;
    #1 chk("bp_ready_high", 32'(ready_out), 32'd1);
    tick();
    valid_in = 1'b0;
    chk("bp_refill_valid", 32'(a_valid_out), 32'd1);
    chk("bp_refill_data", 32'(a_data_out), 32'hA2);
    tick();
    chk("bp_drained", 32'(a_valid_out), 32'd0);

    // Independence: A stalled while B streams
    a_ready_in = 1'b0; b_ready_in = 1'b1;
    valid_in = 1'b1; sel_in = 1'b0; data_in = 8'h40;
    tick();
    sel_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 8'(8'h30 + i);
      #1 chk("ind_ready", 32'(ready_out), 32'd1);
      tick();
      chk("ind_b_data", 32'(b_data_out), 32'(8'h30 + i));
      chk("ind_b_valid", 32'(b_valid_out), 32'd1);
    end
    valid_in = 1'b0;
    chk("ind_a_valid", 32'(a_valid_out), 32'd1);
    chk("ind_a_data", 32'(a_data_out), 32'h40);
    tick();
    chk("ind_b_drained", 32'(b_valid_out), 32'd0);

    // Flush priority with both slots full
    b_ready_in = 1'b0;
    valid_in = 1'b1; sel_in = 1'b1; data_in = 8'h77;
    tick();
    chk("fl_b_full", 32'(b_valid_out), 32'd1);
    flush_in = 1'b1; sel_in = 1'b0; data_in = 8'h99;
    #1 chk("fl_ready", 32'(ready_out), 32'd0);
    tick();
    flush_in = 1'b0; valid_in = 1'b0;
    chk("fl_a_valid", 32'(a_valid_out), 32'd0);
    chk("fl_b_valid", 32'(b_valid_out), 32'd0);
    chk("fl_a_data_kept", 32'(a_data_out), 32'h40);
    tick();
    chk("fl_no_accept", 32'(a_valid_out), 32'd0);

    // Async reset mid-stream with A full
    a_ready_in = 1'b0;
    valid_in = 1'b1; sel_in = 1'b0; data_in = 8'h5A;
    tick();
    valid_in = 1'b0;
    chk("ar_a_full", 32'(a_valid_out), 32'd1);
    chk("ar_a_data", 32'(a_data_out), 32'h5A);
    rst = 1'b1;
    #1;
    chk("ar_a_valid_async", 32'(a_valid_out), 32'd0);
    rst = 1'b0;
    #1 chk("ar_ready_after", 32'(ready_out), 32'd1);
    tick();

    // Randomized traffic against the queue model
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      model_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  8'(accepted + $urandom_range(0, 1) * 8'h80),
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
                  1'($urandom_range(0, 99) == 0));
      cyc++;
    end
    chk("rand_budget", 32'(accepted >= 1000), 32'd1);
    for (int i = 0; i < 4; i++) model_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("rand_a_empty", 32'(a_valid_out), 32'd0);
    chk("rand_b_empty", 32'(b_valid_out), 32'd0);
    chk("rand_conserve", 32'(popped + dropped), 32'(accepted));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_demux_2_way_reg
